ahb_lite_master: RTL and testbench

AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

---
 rtl/ahb_lite_master.sv | 189 ++++++++++++++++++
 tb/tb_ahb_lite_master.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_master.sv
// ahb_lite_master: command-to-AHB-Lite bridge issuing single NONSEQ transfers, one at a time.
//   HCLK, HRESETn              : clock, asynchronous active-low reset
//   cmd_valid/ready/write/addr/size/wdata : command handshake (accepted in IDLE only)
//   rsp_valid/rdata/err        : one-cycle response per accepted command
//   HADDR/HTRANS/HWRITE/HSIZE/HWDATA, HRDATA/HREADY/HRESP : AHB-Lite master bus
// Misaligned commands are answered with an error and never reach the bus. A data phase stuck
// with HREADY=0 for TIMEOUT cycles is abandoned and answered with an error.

package slave_package;
  typedef enum logic [2:0] {
    BYTE      = 3'd0,
    HALF_WORD = 3'd1,
    WORD      = 3'd2
  } HSIZE_E;
endpackage

module ahb_lite_master #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [31:0]           cmd_addr,
  input  slave_package::HSIZE_E cmd_size,
  input  logic [31:0]           cmd_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [31:0]           HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output slave_package::HSIZE_E HSIZE,
  output logic [31:0]           HWDATA,
  input  logic [31:0]           HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e                state_q, state_d;
  logic                  write_q, write_d;
  logic [31:0]           addr_q, addr_d;
  slave_package::HSIZE_E size_q, size_d;
  logic [31:0]           hwdata_q, hwdata_d;
  logic [CntW-1:0]       wait_cnt_q, wait_cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;

  logic        accept, misaligned, complete, timeout;
  logic [31:0] rd_lane;
  logic [31:0] wd_lane;

  assign accept     = cmd_valid & cmd_ready;
  assign misaligned = ((cmd_size == slave_package::HALF_WORD) && cmd_addr[0]) ||
                      ((cmd_size == slave_package::WORD) && (cmd_addr[1:0] != 2'b00));
  assign complete   = (state_q == StData) && HREADY;
  // Abort on the TIMEOUT-th consecutive wait cycle of the data phase.
  assign timeout    = (state_q == StData) && !HREADY && (wait_cnt_q == TimeoutLast);

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept && !misaligned) state_d = StAddr;
      StAddr: if (HREADY) state_d = StData;
      StData: if (complete || timeout) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    cmd_ready = (state_q == StIdle);
    HTRANS    = (state_q == StAddr) ? 2'b10 : 2'b00;
  end

  // Write data lane replication, computed at capture so HWDATA is a plain register.
  always_comb begin
    case (cmd_size)
      slave_package::BYTE:      wd_lane = {4{cmd_wdata[7:0]}};
      slave_package::HALF_WORD: wd_lane = {2{cmd_wdata[15:0]}};
      default:                  wd_lane = cmd_wdata;
    endcase
  end

  // Read data lane extraction using the captured address and size.
  always_comb begin
    case (size_q)
      slave_package::BYTE: begin
        case (addr_q[1:0])
          2'd0:    rd_lane = {24'h0, HRDATA[7:0]};
          2'd1:    rd_lane = {24'h0, HRDATA[15:8]};
          2'd2:    rd_lane = {24'h0, HRDATA[23:16]};
          default: rd_lane = {24'h0, HRDATA[31:24]};
        endcase
      end
      slave_package::HALF_WORD: rd_lane = addr_q[1] ? {16'h0, HRDATA[31:16]}
                                                    : {16'h0, HRDATA[15:0]};
      default:                  rd_lane = HRDATA;
    endcase
  end

  // Datapath next-state
  always_comb begin
    write_d     = write_q;
    addr_d      = addr_q;
    size_d      = size_q;
    hwdata_d    = hwdata_q;
    wait_cnt_d  = wait_cnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'h0;

    // Only aligned commands touch the bus-visible registers, so HADDR etc. keep
    // their last transfer's values across a rejected command.
    if (accept && !misaligned) begin
      write_d  = cmd_write;
      addr_d   = cmd_addr;
      size_d   = cmd_size;
      hwdata_d = wd_lane;
    end

    if ((state_q == StAddr) && HREADY) begin
      wait_cnt_d = '0;
    end else if ((state_q == StData) && !HREADY) begin
      wait_cnt_d = wait_cnt_q + CntW'(1);
    end

    if (accept && misaligned) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
    end else if (complete) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = HRESP;
      rsp_rdata_d = (!write_q && !HRESP) ? rd_lane : 32'h0;
    end else if (timeout) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      write_q     <= 1'b0;
      addr_q      <= 32'h0;
      size_q      <= slave_package::BYTE;
      hwdata_q    <= 32'h0;
      wait_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      write_q     <= write_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      hwdata_q    <= hwdata_d;
      wait_cnt_q  <= wait_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign HADDR     = addr_q;
  assign HWRITE    = write_q;
  assign HSIZE     = size_q;
  assign HWDATA    = hwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Testbench for ahb_lite_master: directed scenarios with a response scoreboard.
module tb_ahb_lite_master;
  import slave_package::*;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = 32'h0;
  HSIZE_E      cmd_size = BYTE;
  logic [31:0] cmd_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  HSIZE_E      HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA = 32'h0;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;

  always #5 HCLK = ~HCLK;

  ahb_lite_master #(.TIMEOUT(64)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_size  (cmd_size),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY),
    .HRESP     (HRESP)
  );

  int nerr = 0;
  int nchk = 0;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Response scoreboard: every rsp_valid cycle must match the oldest expectation.
  always @(posedge HCLK) begin
    exp_t e;
    #1;
    if (rsp_valid === 1'b1) begin
      nchk++;
      if (exp_q.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 err=%b rdata=%h, required no response",
                 rsp_err, rsp_rdata);
      end else begin
        e = exp_q.pop_front();
        if (rsp_err !== e.err || rsp_rdata !== e.rdata) begin
          nerr++;
          $display("FAIL rsp_data: got err=%b rdata=%h, required err=%b rdata=%h",
                   rsp_err, rsp_rdata, e.err, e.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $display("Result: errors=%0d of %0d checks", nerr + 1, nchk + 1);
    $fatal(1);
  end

  // Present a command in the current cycle; returns one cycle later (T+1).
  task automatic issue(input logic w, input logic [31:0] a, input HSIZE_E s,
                       input logic [31:0] wd);
    nchk++;
    if (cmd_ready !== 1'b1) begin
      nerr++;
      $display("FAIL cmd_ready_idle: got %b required 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_size  = s;
    cmd_wdata = wd;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Zero-wait transfer; returns in the response cycle (T+3).
  task automatic run_xfer(input logic w, input logic [31:0] a, input HSIZE_E s,
                          input logic [31:0] wd, input logic [31:0] exp_hwdata,
                          input logic [31:0] rd, input logic [31:0] exp_rdata);
    exp_q.push_back('{1'b0, exp_rdata});
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = rd;
    issue(w, a, s, wd);
    nchk++;
    if (HTRANS !== 2'b10 || HADDR !== a || HWRITE !== w || HSIZE !== s) begin
      nerr++;
      $display("FAIL addr_phase: got trans=%b addr=%h write=%b size=%0d, required 10 %h %b %0d",
               HTRANS, HADDR, HWRITE, HSIZE, a, w, s);
    end
    tick();
    nchk++;
    if (HTRANS !== 2'b00 || (w && HWDATA !== exp_hwdata)) begin
      nerr++;
      $display("FAIL data_phase: got trans=%b hwdata=%h, required 00 %h", HTRANS, HWDATA,
               exp_hwdata);
    end
    tick();
    nchk++;
    if (rsp_valid !== 1'b1 || cmd_ready !== 1'b1) begin
      nerr++;
      $display("FAIL rsp_latency: got rsp_valid=%b cmd_ready=%b, required 1 1",
               rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    tick();
    nchk++;
    if (HTRANS !== 2'b00 || HADDR !== 32'h0 || HWRITE !== 1'b0 || HSIZE !== BYTE ||
        HWDATA !== 32'h0) begin
      nerr++;
      $display("FAIL reset_bus: got trans=%b addr=%h write=%b size=%0d wdata=%h, required 0s",
               HTRANS, HADDR, HWRITE, HSIZE, HWDATA);
    end
    nchk++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      nerr++;
      $display("FAIL reset_rsp: got valid=%b err=%b rdata=%h, required 0 0 0",
               rsp_valid, rsp_err, rsp_rdata);
    end
    HRESETn = 1'b1;
    tick();
    nchk++;
    if (cmd_ready !== 1'b1) begin
      nerr++;
      $display("FAIL reset_ready: got %b required 1", cmd_ready);
    end
  endtask

  task automatic test_word_write();
    exp_q.push_back('{1'b0, 32'h0});
    HREADY = 1'b1;
    issue(1'b1, 32'h0000_0010, WORD, 32'hDEAD_BEEF);
    nchk++;
    if (HTRANS !== 2'b10 || HADDR !== 32'h10 || HWRITE !== 1'b1 || HSIZE !== WORD) begin
      nerr++;
      $display("FAIL word_write_addr: got trans=%b addr=%h, required 10 00000010", HTRANS, HADDR);
    end
    tick();
    nchk++;
    if (HTRANS !== 2'b00 || HWDATA !== 32'hDEAD_BEEF || cmd_ready !== 1'b0) begin
      nerr++;
      $display("FAIL word_write_data: got trans=%b hwdata=%h ready=%b, required 00 deadbeef 0",
               HTRANS, HWDATA, cmd_ready);
    end
    tick();
    nchk++;
    if (rsp_valid !== 1'b1) begin
      nerr++;
      $display("FAIL word_write_rsp: got rsp_valid=%b required 1", rsp_valid);
    end
    tick();
    nchk++;
    if (rsp_valid !== 1'b0) begin
      nerr++;
      $display("FAIL rsp_one_cycle: got rsp_valid=%b required 0", rsp_valid);
    end
  endtask

  task automatic test_byte_wait();
    exp_q.push_back('{1'b0, 32'h0});
    HREADY = 1'b1;
    issue(1'b1, 32'h0000_0003, BYTE, 32'h0000_00A5);
    tick();
    // T+2..T+12: ten wait cycles then completion.
    for (int i = 0; i <= 10; i++) begin
      HREADY = (i == 10);
      nchk++;
      if (HWDATA !== 32'hA5A5_A5A5 || HTRANS !== 2'b00 || rsp_valid !== 1'b0) begin
        nerr++;
        $display("FAIL byte_wait_hold[%0d]: got hwdata=%h trans=%b rsp=%b, required a5a5a5a5 00 0",
                 i, HWDATA, HTRANS, rsp_valid);
      end
      tick();
    end
    nchk++;
    if (rsp_valid !== 1'b1) begin
      nerr++;
      $display("FAIL byte_wait_rsp: got rsp_valid=%b required 1", rsp_valid);
    end
  endtask

  // Back-to-back: each command is presented in the previous response cycle.
  task automatic test_back_to_back();
    run_xfer(1'b0, 32'h0000_0002, HALF_WORD, 32'h0, 32'h0, 32'hABCD_1234, 32'h0000_ABCD);
    run_xfer(1'b0, 32'h0000_0000, HALF_WORD, 32'h0, 32'h0, 32'hABCD_1234, 32'h0000_1234);
    run_xfer(1'b0, 32'h0000_0100, BYTE, 32'h0, 32'h0, 32'hABCD_1234, 32'h0000_0034);
    run_xfer(1'b0, 32'h0000_0101, BYTE, 32'h0, 32'h0, 32'hABCD_1234, 32'h0000_0012);
    run_xfer(1'b0, 32'h0000_0102, BYTE, 32'h0, 32'h0, 32'hABCD_1234, 32'h0000_00CD);
    run_xfer(1'b0, 32'h0000_0103, BYTE, 32'h0, 32'h0, 32'hABCD_1234, 32'h0000_00AB);
    run_xfer(1'b0, 32'h0000_0204, WORD, 32'h0, 32'h0, 32'h1357_9BDF, 32'h1357_9BDF);
    run_xfer(1'b1, 32'h0000_0302, HALF_WORD, 32'h1234_BEEF, 32'hBEEF_BEEF, 32'hFFFF_FFFF,
             32'h0);
    run_xfer(1'b1, 32'h0000_0400, WORD, 32'h0BAD_F00D, 32'h0BAD_F00D, 32'hFFFF_FFFF, 32'h0);
    tick();
  endtask

  task automatic test_misaligned();
    HSIZE_E      sz[4] = '{WORD, WORD, HALF_WORD, HALF_WORD};
    logic [31:0] ad[4] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{1'b1, 32'h0});
      issue(1'b0, ad[i], sz[i], 32'h0);
      nchk++;
      if (HTRANS !== 2'b00 || rsp_valid !== 1'b1 || cmd_ready !== 1'b1) begin
        nerr++;
        $display("FAIL misaligned[%0d]: got trans=%b rsp=%b ready=%b, required 00 1 1",
                 i, HTRANS, rsp_valid, cmd_ready);
      end
    end
    tick();
    nchk++;
    if (rsp_valid !== 1'b0 || HTRANS !== 2'b00) begin
      nerr++;
      $display("FAIL misaligned_quiet: got rsp=%b trans=%b, required 0 00", rsp_valid, HTRANS);
    end
  endtask

  task automatic test_timeout();
    exp_q.push_back('{1'b1, 32'h0});
    HREADY = 1'b1;
    HRDATA = 32'hFFFF_FFFF;
    issue(1'b0, 32'h0000_0020, WORD, 32'h0);
    tick();
    HREADY = 1'b0;
    // DATA wait cycles T+2..T+65; response expected at T+66.
    for (int i = 0; i < 63; i++) tick();
    nchk++;
    if (rsp_valid !== 1'b0) begin
      nerr++;
      $display("FAIL timeout_early: got rsp_valid=%b required 0 at wait 64", rsp_valid);
    end
    tick();
    nchk++;
    if (rsp_valid !== 1'b1 || HTRANS !== 2'b00 || cmd_ready !== 1'b1) begin
      nerr++;
      $display("FAIL timeout_rsp: got rsp=%b trans=%b ready=%b, required 1 00 1",
               rsp_valid, HTRANS, cmd_ready);
    end
    HREADY = 1'b1;
    tick();
  endtask

  task automatic test_error_resp();
    exp_q.push_back('{1'b1, 32'h0});
    HREADY = 1'b1;
    issue(1'b1, 32'h0000_0040, WORD, 32'h1111_2222);
    tick();
    HREADY = 1'b0;
    HRESP  = 1'b1;
    tick();
    nchk++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      nerr++;
      $display("FAIL err_first_cycle: got rsp=%b ready=%b, required 0 0", rsp_valid, cmd_ready);
    end
    HREADY = 1'b1;
    tick();
    HRESP = 1'b0;
    nchk++;
    if (rsp_valid !== 1'b1) begin
      nerr++;
      $display("FAIL err_rsp: got rsp_valid=%b required 1", rsp_valid);
    end
    tick();
  endtask

  task automatic test_reset_in_data();
    HREADY = 1'b1;
    issue(1'b1, 32'h0000_0080, HALF_WORD, 32'h0000_5A5A);
    tick();
    HREADY = 1'b0;
    nchk++;
    if (HWDATA !== 32'h5A5A_5A5A) begin
      nerr++;
      $display("FAIL rst_pre_hwdata: got %h required 5a5a5a5a", HWDATA);
    end
    tick();
    #2;
    HRESETn = 1'b0;
    #1;
    nchk++;
    if (HTRANS !== 2'b00 || HADDR !== 32'h0 || HWRITE !== 1'b0 || HSIZE !== BYTE ||
        HWDATA !== 32'h0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 ||
        cmd_ready !== 1'b1) begin
      nerr++;
      $display("FAIL rst_async: got trans=%b addr=%h wr=%b size=%0d wd=%h rv=%b ready=%b",
               HTRANS, HADDR, HWRITE, HSIZE, HWDATA, rsp_valid, cmd_ready);
    end
    tick();
    tick();
    HRESETn = 1'b1;
    HREADY  = 1'b1;
    tick();
    nchk++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || HTRANS !== 2'b00) begin
      nerr++;
      $display("FAIL rst_release: got ready=%b rsp=%b trans=%b, required 1 0 00",
               cmd_ready, rsp_valid, HTRANS);
    end
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_word_write();
    test_byte_wait();
    test_back_to_back();
    test_misaligned();
    test_timeout();
    test_error_resp();
    test_reset_in_data();
    tick();
    nchk++;
    if (exp_q.size() != 0) begin
      nerr++;
      $display("FAIL missing_rsp: got %0d outstanding responses, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
